// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the processing-element controller:
// FSM state encoding and the DIMEN code to vector-length mapping.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_A,
    S_RADDR,
    S_LOAD_B,
    S_MAC,
    S_RESULT,
    S_HOLD
  } state_e;

  localparam int          CNT_W  = 5;
  localparam logic [4:0]  LEN_D0 = 5'd2;
  localparam logic [4:0]  LEN_D1 = 5'd4;
  localparam logic [4:0]  LEN_D2 = 5'd8;
  localparam logic [4:0]  LEN_D3 = 5'd16;

  function automatic logic [4:0] dimen_len(input logic [1:0] code);
    case (code)
      2'd0:    dimen_len = LEN_D0;
      2'd1:    dimen_len = LEN_D1;
      2'd2:    dimen_len = LEN_D2;
      default: dimen_len = LEN_D3;
    endcase
  endfunction

endpackage

// File: rtl/pe_controller.sv
// Sequencer for one Processing_Element: loads A then B operand vectors,
// runs the MAC with a timeout watchdog, and returns the dot product.
module pe_controller
  import pe_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [1:0]  DIMEN,
  input  logic        ABORT,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [31:0] RES_DATA,
  output logic        BUSY,
  output logic        ERR,
  output logic        RST_ADD,
  output logic        RST_ACC,
  output logic        RST_PC,
  output logic        MAC_CTRL,
  output logic        MAT_MUX,
  output logic        WRITE_MAT,
  output logic        OUT_READY,
  output logic [1:0]  DIMEN_PE,
  output logic [31:0] DATAIN,
  input  logic        MAC_DONE,
  input  logic [31:0] DATAOUT
);

  // Vector length can never exceed the PE matrix depth.
  localparam int MAX_LEN = (N < 16) ? N : 16;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   mac_cnt_q, mac_cnt_d;
  logic [1:0]         dimen_q, dimen_d;
  logic               err_q, err_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic [4:0]         len;

  always_comb begin
    len = dimen_len(dimen_q);
    if (len > 5'(MAX_LEN)) len = 5'(MAX_LEN);
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    mac_cnt_d   = mac_cnt_q;
    dimen_d     = dimen_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    RST_ADD     = 1'b0;
    RST_ACC     = 1'b0;
    RST_PC      = 1'b0;
    MAC_CTRL    = 1'b0;
    MAT_MUX     = 1'b0;
    WRITE_MAT   = 1'b0;
    OUT_READY   = 1'b0;
    DATAIN      = '0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          dimen_d    = DIMEN;
          err_d      = 1'b0;
          word_cnt_d = '0;
          mac_cnt_d  = '0;
          state_d    = S_CLR;
        end
      end
      S_CLR: begin
        RST_ADD = 1'b1;
        RST_ACC = 1'b1;
        RST_PC  = 1'b1;
        state_d = S_LOAD_A;
      end
      S_LOAD_A, S_LOAD_B: begin
        MAT_MUX   = (state_q == S_LOAD_A);
        WRITE_MAT = IN_VALID;
        DATAIN    = IN_DATA;
        if (IN_VALID) begin
          if (word_cnt_q + 5'd1 == len) begin
            word_cnt_d = '0;
            state_d    = (state_q == S_LOAD_A) ? S_RADDR : S_MAC;
          end else begin
            word_cnt_d = word_cnt_q + 5'd1;
          end
        end
      end
      S_RADDR: begin
        RST_ADD = 1'b1;
        state_d = S_LOAD_B;
      end
      S_MAC: begin
        MAC_CTRL = ~MAC_DONE;
        if (MAC_DONE) begin
          mac_cnt_d = '0;
          state_d   = S_RESULT;
        end else if (mac_cnt_q == len + 5'd1) begin
          // Watchdog: MAC_CTRL has now been high for L+2 cycles.
          mac_cnt_d = '0;
          err_d     = 1'b1;
          state_d   = S_RESULT;
        end else begin
          mac_cnt_d = mac_cnt_q + 5'd1;
        end
      end
      S_RESULT: begin
        OUT_READY   = 1'b1;
        res_data_d  = DATAOUT;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ABORT && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      word_cnt_d  = '0;
      mac_cnt_d   = '0;
    end

    in_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      mac_cnt_q   <= '0;
      dimen_q     <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      mac_cnt_q   <= mac_cnt_d;
      dimen_q     <= dimen_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign DIMEN_PE  = dimen_q;

endmodule

// File: tb/tb_pe_controller.sv
// Directed bench for pe_controller with a small behavioural PE model that
// stores the operand vectors and finishes its MAC after L cycles.
module tb_pe_controller;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START = 1'b0;
  logic [1:0]  DIMEN = 2'd0;
  logic        ABORT = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_DATA = '0;
  logic        RES_VALID;
  logic        RES_READY = 1'b1;
  logic [31:0] RES_DATA;
  logic        BUSY, ERR;
  logic        RST_ADD, RST_ACC, RST_PC, MAC_CTRL, MAT_MUX, WRITE_MAT, OUT_READY;
  logic [1:0]  DIMEN_PE;
  logic [31:0] DATAIN;
  logic        MAC_DONE;
  logic [31:0] DATAOUT;

  pe_controller #(.N(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .DIMEN(DIMEN), .ABORT(ABORT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .BUSY(BUSY), .ERR(ERR),
    .RST_ADD(RST_ADD), .RST_ACC(RST_ACC), .RST_PC(RST_PC), .MAC_CTRL(MAC_CTRL),
    .MAT_MUX(MAT_MUX), .WRITE_MAT(WRITE_MAT), .OUT_READY(OUT_READY),
    .DIMEN_PE(DIMEN_PE), .DATAIN(DATAIN), .MAC_DONE(MAC_DONE), .DATAOUT(DATAOUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural Processing_Element
  bit [31:0] mem_a [16];
  bit [31:0] mem_b [16];
  int        pe_addr = 0;
  int        pe_mac_cnt = 0;
  bit        force_low = 1'b0;
  int        len_pe;
  logic [31:0] dot;

  always @(posedge CLK) begin
    if (RST_ADD) pe_addr <= 0;
    else if (WRITE_MAT) pe_addr <= pe_addr + 1;
    if (WRITE_MAT && pe_addr < 16) begin
      if (MAT_MUX) mem_a[pe_addr] <= DATAIN;
      else         mem_b[pe_addr] <= DATAIN;
    end
    if (RST_ACC) pe_mac_cnt <= 0;
    else if (MAC_CTRL) pe_mac_cnt <= pe_mac_cnt + 1;
  end

  always_comb begin
    len_pe = 2 << DIMEN_PE;
    dot = '0;
    for (int i = 0; i < 16; i++)
      if (i < len_pe) dot = dot + mem_a[i] * mem_b[i];
  end

  assign MAC_DONE = !force_low && (pe_mac_cnt >= len_pe);
  assign DATAOUT  = dot;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] stim [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one operation; returns cycles from the START edge to RES_VALID,
  // cycles with MAC_CTRL high, and words accepted.
  task automatic do_op(input logic [1:0] d, input int n, input bit toggle,
                       input int abort_at, output int lat, output int macs,
                       output int taken);
    int idx;
    bit acc;
    DIMEN = d;
    START = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 32'hDEAD;
    tick();
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    chk("rst_pc_in_clr", {31'd0, RST_PC}, 32'd1);
    chk("err_cleared_on_start", {31'd0, ERR}, 32'd0);
    lat = 0; macs = 0; idx = 0;
    while (!RES_VALID && lat < 200) begin
      IN_VALID = (idx < n) && (!toggle || (lat % 2 == 0));
      IN_DATA  = IN_VALID ? stim[idx] : 32'd0;
      ABORT    = (abort_at >= 0) && (idx == abort_at) && IN_READY;
      acc      = IN_VALID && IN_READY;
      if (MAC_CTRL) macs++;
      tick();
      lat++;
      if (acc) idx++;
      if (ABORT) begin
        ABORT = 1'b0;
        break;
      end
    end
    IN_VALID = 1'b0;
    taken = idx;
    $display("op dimen=%0d words=%0d res_valid=%0b res=%0d latency=%0d mac_cycles=%0d err=%0b",
             d, idx, RES_VALID, RES_DATA, lat, macs, ERR);
  endtask

  initial begin
    int lat, macs, taken, cyc, idx;
    bit acc;

    // Reset state
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_res_valid", {31'd0, RES_VALID}, 32'd0);
    chk("rst_res_data", RES_DATA, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_dimen_pe", {30'd0, DIMEN_PE}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd0);
    chk("rst_pe_ctrl", {25'd0, RST_ADD, RST_ACC, RST_PC, MAC_CTRL, MAT_MUX, WRITE_MAT, OUT_READY}, 32'd0);
    tick(); tick();
    RSTN = 1'b1;
    tick();

    // L=2: {2,3}.{4,5} = 23, RES_VALID 10 cycles after START
    stim[0] = 2; stim[1] = 3; stim[2] = 4; stim[3] = 5;
    do_op(2'd0, 4, 1'b0, -1, lat, macs, taken);
    chk("l2_latency", lat, 32'd10);
    chk("l2_res_data", RES_DATA, 32'd23);
    chk("l2_mac_cycles", macs, 32'd2);
    chk("l2_err", {31'd0, ERR}, 32'd0);
    tick();
    chk("l2_valid_cleared", {31'd0, RES_VALID}, 32'd0);
    chk("l2_idle", {31'd0, BUSY}, 32'd0);

    // ABORT in IDLE does nothing
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_idle_busy", {31'd0, BUSY}, 32'd0);

    // L=16, gappy input stream: 16 ones then 16 twos
    for (int i = 0; i < 16; i++) begin
      stim[i] = 1;
      stim[i + 16] = 2;
    end
    do_op(2'd3, 32, 1'b1, -1, lat, macs, taken);
    chk("l16_done", {31'd0, RES_VALID}, 32'd1);
    chk("l16_res_data", RES_DATA, 32'd32);
    chk("l16_words", taken, 32'd32);
    chk("l16_dimen_pe", {30'd0, DIMEN_PE}, 32'd3);
    tick();
    chk("l16_idle", {31'd0, BUSY}, 32'd0);

    // L=4 with RES_READY held low: {1,2,3,4}.{5,6,7,8} = 70
    for (int i = 0; i < 8; i++) stim[i] = i + 1;
    RES_READY = 1'b0;
    do_op(2'd1, 8, 1'b0, -1, lat, macs, taken);
    chk("l4_latency", lat, 32'd16);
    chk("l4_res_data", RES_DATA, 32'd70);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'd0, RES_VALID}, 32'd1);
      chk("hold_data", RES_DATA, 32'd70);
    end
    RES_READY = 1'b1;
    tick();
    chk("hold_release_valid", {31'd0, RES_VALID}, 32'd0);
    chk("hold_release_idle", {31'd0, BUSY}, 32'd0);

    // ABORT in the second LOAD_B cycle, then a clean L=2 run
    do_op(2'd1, 8, 1'b0, 5, lat, macs, taken);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_in_ready", {31'd0, IN_READY}, 32'd0);
    chk("abort_res_valid", {31'd0, RES_VALID}, 32'd0);
    chk("abort_mac_ctrl", {31'd0, MAC_CTRL}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) stim[i] = 1;
    do_op(2'd0, 4, 1'b0, -1, lat, macs, taken);
    chk("after_abort_latency", lat, 32'd10);
    chk("after_abort_res", RES_DATA, 32'd2);
    tick();

    // MAC_DONE stuck low: watchdog after 4 MAC cycles
    stim[0] = 1; stim[1] = 2; stim[2] = 3; stim[3] = 4;
    force_low = 1'b1;
    do_op(2'd0, 4, 1'b0, -1, lat, macs, taken);
    force_low = 1'b0;
    chk("timeout_mac_cycles", macs, 32'd4);
    chk("timeout_latency", lat, 32'd11);
    chk("timeout_err", {31'd0, ERR}, 32'd1);
    chk("timeout_res_valid", {31'd0, RES_VALID}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, ERR}, 32'd1);

    // START ignored while busy, then async reset in MAC
    for (int i = 0; i < 8; i++) stim[i] = i + 1;
    DIMEN = 2'd1;
    START = 1'b1;
    tick();
    DIMEN = 2'd3;
    cyc = 0; idx = 0;
    while (!MAC_CTRL && cyc < 100) begin
      IN_VALID = (idx < 8);
      IN_DATA  = IN_VALID ? stim[idx] : 32'd0;
      acc = IN_VALID && IN_READY;
      tick();
      cyc++;
      if (acc) idx++;
    end
    START = 1'b0;
    IN_VALID = 1'b0;
    chk("reached_mac", {31'd0, MAC_CTRL}, 32'd1);
    chk("start_ignored_busy", {30'd0, DIMEN_PE}, 32'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("async_busy", {31'd0, BUSY}, 32'd0);
    chk("async_mac_ctrl", {31'd0, MAC_CTRL}, 32'd0);
    chk("async_res_data", RES_DATA, 32'd0);
    chk("async_err", {31'd0, ERR}, 32'd0);
    chk("async_dimen_pe", {30'd0, DIMEN_PE}, 32'd0);
    tick();
    RSTN = 1'b1;
    tick();
    $display("reset applied mid-MAC after %0d cycles", cyc);

    stim[0] = 2; stim[1] = 3; stim[2] = 4; stim[3] = 5;
    do_op(2'd0, 4, 1'b0, -1, lat, macs, taken);
    chk("post_reset_latency", lat, 32'd10);
    chk("post_reset_res", RES_DATA, 32'd23);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_controller.md
PE_CONTROLLER -- requirements
Module: pe_controller

Interface
REQ-001 SHALL have parameter N, default 32, giving the PE matrix depth; only vector lengths of 16 or less are used.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port START, input, 1 bit: requests one dot-product operation; sampled only in IDLE.
REQ-005 SHALL have port DIMEN, input, 2 bits: length code L = 2, 4, 8 or 16 for codes 0 to 3; latched when START is accepted.
REQ-006 SHALL have port ABORT, input, 1 bit: synchronous cancel of the current operation.
REQ-007 SHALL have ports IN_VALID (input, 1 bit), IN_READY (output, 1 bit) and IN_DATA (input, 32 bits): the operand stream, A words first, then B words.
REQ-008 SHALL have ports RES_VALID (output, 1 bit), RES_READY (input, 1 bit) and RES_DATA (output, 32 bits): the result handshake.
REQ-009 SHALL have ports BUSY (output, 1 bit: state is not IDLE) and ERR (output, 1 bit: sticky MAC timeout flag).
REQ-010 SHALL drive the PE-side outputs RST_ADD, RST_ACC, RST_PC, MAC_CTRL, MAT_MUX, WRITE_MAT, OUT_READY (1 bit each), DIMEN_PE (2 bits) and DATAIN (32 bits).
REQ-011 SHALL take the PE-side inputs MAC_DONE (1 bit) and DATAOUT (32 bits).

Function
REQ-012 SHALL implement the FSM states IDLE, CLR, LOAD_A, RADDR, LOAD_B, MAC, RESULT and HOLD.
REQ-013 SHALL move IDLE to CLR on START, latching DIMEN into DIMEN_PE and clearing ERR.
REQ-014 CLR SHALL assert RST_ADD, RST_ACC and RST_PC for exactly one cycle, then go to LOAD_A.
REQ-015 LOAD_A and LOAD_B SHALL assert IN_READY, with WRITE_MAT = IN_VALID and DATAIN = IN_DATA; MAT_MUX SHALL be 1 in LOAD_A and 0 in LOAD_B.
REQ-016 A 5-bit word counter SHALL increment on each IN_VALID&IN_READY; the state SHALL advance on the accepted word that makes the count L, and the counter SHALL clear.
REQ-017 RADDR SHALL assert RST_ADD for one cycle between LOAD_A and LOAD_B, with IN_READY low.
REQ-018 MAC SHALL assert MAC_CTRL = ~MAC_DONE and SHALL go to RESULT in the cycle MAC_DONE is high.
REQ-019 If MAC_CTRL has been high for L+2 cycles without MAC_DONE, MAC SHALL set ERR and go to RESULT.
REQ-020 RESULT SHALL assert OUT_READY, register RES_DATA <= DATAOUT, set RES_VALID, and go to HOLD.
REQ-021 HOLD SHALL keep RES_VALID and RES_DATA stable until RES_VALID&RES_READY, then return to IDLE with RES_VALID cleared.
REQ-022 With no stalls, RES_VALID SHALL rise 3L+4 cycles after the edge that samples START.
REQ-023 The PE-side outputs SHALL be combinational decodes of the registered state plus IN_VALID/IN_DATA and MAC_DONE; all other outputs SHALL be registered.
REQ-024 ABORT SHALL take priority over all transitions: the next state is IDLE, and RES_VALID, IN_READY and MAC_CTRL are low on the next cycle.
REQ-025 START SHALL be ignored outside IDLE; ABORT SHALL be a no-op in IDLE.
REQ-026 IN_VALID SHALL be ignored whenever IN_READY is low.

Reset
REQ-027 While RSTN is low: state = IDLE, counters = 0, RES_VALID = 0, RES_DATA = 0, ERR = 0, DIMEN_PE = 0, and all PE-side control outputs = 0.
REQ-028 Reset mid-operation SHALL abandon the operation; the next START SHALL run a full CLR sequence.

Structure
REQ-029 A package pe_ctrl_pkg SHALL hold the state enum and the DIMEN-to-length constants (2, 4, 8, 16).
REQ-030 The block SHALL be a single module with no sub-module; it is instantiated alongside one Processing_Element.

Verification
REQ-031 DIMEN=0, A={2,3}, B={4,5}, RES_READY=1 -> RES_DATA=23, with RES_VALID at cycle 10 after START.
REQ-032 DIMEN=3, A=all 1, B=all 2, with IN_VALID toggling every other cycle -> RES_DATA=32, and no word is lost or duplicated.
REQ-033 DIMEN=1, RES_READY low for 5 cycles in HOLD -> RES_VALID and RES_DATA held constant, then IDLE one cycle after RES_READY rises.
REQ-034 ABORT in the 2nd LOAD_B cycle -> BUSY=0 next cycle, IN_READY=0; a following DIMEN=0 run with {1,1}x{1,1} -> RES_DATA=2.
REQ-035 MAC_DONE forced low in MAC with DIMEN=0 -> ERR=1 after 4 MAC cycles, RES_VALID asserted.
REQ-036 RSTN pulsed low mid-MAC -> all outputs at reset values asynchronously; START while BUSY=1 is ignored.
